// File: rtl/som_pkg.sv
// SOM shared constants, FSM encoding and RGB channel helper (combinational only).
// Also used by the minimum-distance search; NEIGHBOR_UPD_EN adds the NBR state.
// No handshake of its own; backpressure is handled by the blocks that import it.
package som_pkg;

  localparam int N_NODES = 8;
  localparam int CH_W    = 8;
  localparam int N_CH    = 3;
  localparam int W_W     = 24;
  localparam int IDX_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_UPD  = 3'd2,
`ifdef NEIGHBOR_UPD_EN
    ST_NBR  = 3'd3,
`endif
    ST_DONE = 3'd4
  } state_t;

  // Channel 0 is B (LSBs), channel 2 is R.
  function automatic logic [CH_W-1:0] ch_sel(input logic [W_W-1:0] v, input int unsigned c);
    return v[c*CH_W +: CH_W];
  endfunction

endpackage

// File: rtl/ch_blend.sv
// One 8-bit channel step toward the sample: w + ((x - w) >>> SHIFT).
// Latency: combinational.
// Backpressure: none; the caller decides when the result is written.
module ch_blend
  import som_pkg::*;
#(
  parameter int SHIFT = 2
)
(
  input  logic [CH_W-1:0] w,
  input  logic [CH_W-1:0] x,
  output logic [CH_W-1:0] w_new
);

  logic signed [CH_W:0] diff;
  logic signed [CH_W:0] step;

  // The 9-bit difference never overflows, and a floor shift of it keeps w + step
  // between w and x, so the narrowing below cannot wrap.
  assign diff  = $signed({1'b0, x}) - $signed({1'b0, w});
  assign step  = diff >>> SHIFT;
  assign w_new = CH_W'($signed({1'b0, w}) + step);

endmodule

// File: rtl/weight_update.sv
// SOM weight bank: 8-beat initial load, then winner (optionally neighbour) updates.
// Latency: update accepted in cycle 0, winner written at the cycle-1 edge, done in cycle 2
// (cycle 3 with NEIGHBOR_UPD_EN). Backpressure: ready only in IDLE; upd_valid is dropped otherwise.
module weight_update
  import som_pkg::*;
#(
  parameter int LR_SHIFT = 2
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init_valid,
  input  logic [W_W-1:0]   init_w,
  input  logic             upd_valid,
  input  logic [W_W-1:0]   x,
  input  logic [IDX_W-1:0] win_index,
  output logic             ready,
  output logic             done,
  output logic [W_W-1:0]   w0,
  output logic [W_W-1:0]   w1,
  output logic [W_W-1:0]   w2,
  output logic [W_W-1:0]   w3,
  output logic [W_W-1:0]   w4,
  output logic [W_W-1:0]   w5,
  output logic [W_W-1:0]   w6,
  output logic [W_W-1:0]   w7,
  output logic [15:0]      upd_cnt
);

  state_t           state;
  logic [W_W-1:0]   w_q [N_NODES];
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_q;
  logic [W_W-1:0]   x_q;
  logic [W_W-1:0]   win_new;
  logic [15:0]      cnt_next;

  assign w0 = w_q[0];
  assign w1 = w_q[1];
  assign w2 = w_q[2];
  assign w3 = w_q[3];
  assign w4 = w_q[4];
  assign w5 = w_q[5];
  assign w6 = w_q[6];
  assign w7 = w_q[7];

  assign cnt_next = (&upd_cnt) ? upd_cnt : upd_cnt + 16'd1;

  for (genvar c = 0; c < N_CH; c++) begin : g_win
    ch_blend #(.SHIFT(LR_SHIFT)) u_blend (
      .w     (ch_sel(w_q[idx_q], c)),
      .x     (ch_sel(x_q, c)),
      .w_new (win_new[c*CH_W +: CH_W])
    );
  end

`ifdef NEIGHBOR_UPD_EN
  logic [IDX_W-1:0] idx_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [W_W-1:0]   lo_new;
  logic [W_W-1:0]   hi_new;

  // Indices wrap here, but the write enables below stop the edge nodes wrapping.
  assign idx_lo = idx_q - IDX_W'(1);
  assign idx_hi = idx_q + IDX_W'(1);

  for (genvar c = 0; c < N_CH; c++) begin : g_nbr
    ch_blend #(.SHIFT(LR_SHIFT + 1)) u_lo (
      .w     (ch_sel(w_q[idx_lo], c)),
      .x     (ch_sel(x_q, c)),
      .w_new (lo_new[c*CH_W +: CH_W])
    );
    ch_blend #(.SHIFT(LR_SHIFT + 1)) u_hi (
      .w     (ch_sel(w_q[idx_hi], c)),
      .x     (ch_sel(x_q, c)),
      .w_new (hi_new[c*CH_W +: CH_W])
    );
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      upd_cnt <= '0;
      for (int i = 0; i < N_NODES; i++) w_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (init_valid) begin
            w_q[0] <= init_w;
            ptr    <= IDX_W'(1);
            state  <= ST_INIT;
            ready  <= 1'b0;
          end else if (upd_valid) begin
            x_q   <= x;
            idx_q <= win_index;
            state <= ST_UPD;
            ready <= 1'b0;
          end
        end
        ST_INIT: begin
          if (init_valid) begin
            w_q[ptr] <= init_w;
            ptr      <= ptr + IDX_W'(1);
            if (ptr == IDX_W'(N_NODES - 1)) begin
              state <= ST_IDLE;
              ready <= 1'b1;
            end
          end
        end
        ST_UPD: begin
          w_q[idx_q] <= win_new;
`ifdef NEIGHBOR_UPD_EN
          state <= ST_NBR;
`else
          state   <= ST_DONE;
          done    <= 1'b1;
          upd_cnt <= cnt_next;
`endif
        end
`ifdef NEIGHBOR_UPD_EN
        ST_NBR: begin
          if (idx_q != '0) w_q[idx_lo] <= lo_new;
          if (idx_q != '1) w_q[idx_hi] <= hi_new;
          state   <= ST_DONE;
          done    <= 1'b1;
          upd_cnt <= cnt_next;
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_update.sv
// Directed bench for weight_update: ramp load, init-vs-update priority, update table,
// and reset during an update. NEIGHBOR_UPD_EN swaps the table for a neighbour sequence.
module tb_weight_update;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_valid;
  logic [23:0] init_w;
  logic        upd_valid;
  logic [23:0] x;
  logic [2:0]  win_index;
  logic        ready;
  logic        done;
  logic [23:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic [15:0] upd_cnt;

  logic [23:0] wv    [8];
  logic [23:0] model [8];
  logic [23:0] lv    [8];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          done_ref;

  typedef struct {
    logic [2:0]  idx;
    logic [23:0] xv;
    logic [23:0] exp_w;
  } vec_t;
  vec_t vecs [8];

  weight_update #(.LR_SHIFT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .init_valid (init_valid),
    .init_w     (init_w),
    .upd_valid  (upd_valid),
    .x          (x),
    .win_index  (win_index),
    .ready      (ready),
    .done       (done),
    .w0         (w0),
    .w1         (w1),
    .w2         (w2),
    .w3         (w3),
    .w4         (w4),
    .w5         (w5),
    .w6         (w6),
    .w7         (w7),
    .upd_cnt    (upd_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = w3;
    wv[4] = w4; wv[5] = w5; wv[6] = w6; wv[7] = w7;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bank(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s w%0d", tag, i), 32'(wv[i]), 32'(model[i]));
  endtask

  initial begin
    vecs[0] = '{3'd3, 24'hFF0000, 24'h9F6060};
    vecs[1] = '{3'd5, 24'h5A5A5A, 24'h5A5A5A};
    vecs[2] = '{3'd0, 24'h000000, 24'h0C1824};
    vecs[3] = '{3'd7, 24'h808080, 24'h7F7F7F};
    vecs[4] = '{3'd4, 24'hFEFDFC, 24'hFEFEFE};
    vecs[5] = '{3'd2, 24'hFF00FF, 24'h470848};
    vecs[6] = '{3'd3, 24'hFF0000, 24'hB74848};
    vecs[7] = '{3'd6, 24'hFF00FF, 24'h3FBF3F};

    lv[0] = 24'h102030; lv[1] = 24'h112233; lv[2] = 24'h0A0B0C; lv[3] = 24'h808080;
    lv[4] = 24'hFFFFFF; lv[5] = 24'h5A5A5A; lv[6] = 24'h00FF00; lv[7] = 24'h7F7F7F;

    rst = 1'b1; init_valid = 1'b0; upd_valid = 1'b0;
    init_w = '0; x = '0; win_index = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (3) tick();
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    chk("reset upd_cnt", 32'(upd_cnt), 32'd0);
    chk_bank("reset");
    rst = 1'b0;
    tick();

    // Ramp load with idle gaps after beats 2 and 5.
    for (int i = 0; i < 8; i++) begin
      init_valid = 1'b1;
      init_w     = 24'(i) * 24'h010101;
      model[i]   = 24'(i) * 24'h010101;
      tick();
      init_valid = 1'b0;
      if (i == 0) chk("ramp busy", 32'(ready), 32'd0);
      if (i == 2 || i == 5) tick();
    end
    chk("ramp ready", 32'(ready), 32'd1);
    chk_bank("ramp");

    // Reload with upd_valid asserted alongside the first beat and held through INIT.
    done_ref = done_cnt;
    for (int i = 0; i < 8; i++) begin
      init_valid = 1'b1;
      init_w     = lv[i];
      model[i]   = lv[i];
      if (i == 0) begin
        upd_valid = 1'b1;
        x         = 24'hFFFFFF;
        win_index = 3'd1;
      end
      tick();
      init_valid = 1'b0;
      if (i == 7) upd_valid = 1'b0;
      if (i == 0) chk("init wins ready", 32'(ready), 32'd0);
    end
    tick();
    chk("init wins upd_cnt", 32'(upd_cnt), 32'd0);
    chk("init wins no done", 32'(done_cnt), 32'(done_ref));
    chk("reload ready", 32'(ready), 32'd1);
    chk_bank("reload");

`ifndef NEIGHBOR_UPD_EN
    for (int k = 0; k < 8; k++) begin
      upd_valid = 1'b1;
      x         = vecs[k].xv;
      win_index = vecs[k].idx;
      tick();
      chk($sformatf("v%0d busy", k), 32'(ready), 32'd0);
      chk($sformatf("v%0d early done", k), 32'(done), 32'd0);
      // Held while busy with different payload; must be dropped, not queued.
      x         = ~vecs[k].xv;
      win_index = vecs[k].idx + 3'd1;
      tick();
      upd_valid = 1'b0;
      chk($sformatf("v%0d w%0d", k, vecs[k].idx), 32'(wv[vecs[k].idx]), 32'(vecs[k].exp_w));
      chk($sformatf("v%0d done", k), 32'(done), 32'd1);
      chk($sformatf("v%0d upd_cnt", k), 32'(upd_cnt), 32'(k + 1));
      model[vecs[k].idx] = vecs[k].exp_w;
      tick();
      chk($sformatf("v%0d done drop", k), 32'(done), 32'd0);
      chk($sformatf("v%0d ready", k), 32'(ready), 32'd1);
      chk_bank($sformatf("v%0d", k));
    end
    tick();
    chk("table upd_cnt", 32'(upd_cnt), 32'd8);
`else
    lv[0] = 24'h000000; lv[1] = 24'h000000; lv[7] = 24'h070707;
    for (int i = 0; i < 8; i++) begin
      init_valid = 1'b1;
      init_w     = lv[i];
      model[i]   = lv[i];
      tick();
      init_valid = 1'b0;
    end
    upd_valid = 1'b1;
    x         = 24'h404040;
    win_index = 3'd0;
    tick();
    upd_valid = 1'b0;
    tick();
    chk("nbr winner w0", 32'(w0), 32'h101010);
    chk("nbr no early done", 32'(done), 32'd0);
    tick();
    chk("nbr done", 32'(done), 32'd1);
    chk("nbr w1", 32'(w1), 32'h080808);
    chk("nbr w7 untouched", 32'(w7), 32'h070707);
    chk("nbr upd_cnt", 32'(upd_cnt), 32'd1);
    model[0] = 24'h101010;
    model[1] = 24'h080808;
    tick();
    chk("nbr done drop", 32'(done), 32'd0);
    chk("nbr ready", 32'(ready), 32'd1);
    chk_bank("nbr");
`endif

    // Reset asserted while the update is in UPD: nothing may complete.
    upd_valid = 1'b1;
    x         = 24'h123456;
    win_index = 3'd2;
    tick();
    upd_valid = 1'b0;
    done_ref  = done_cnt;
    rst       = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    #1;
    chk("rst upd_cnt", 32'(upd_cnt), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst ready", 32'(ready), 32'd1);
    chk_bank("rst");
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post rst ready", 32'(ready), 32'd1);
    chk("post rst no done", 32'(done_cnt), 32'(done_ref));
    chk("post rst upd_cnt", 32'(upd_cnt), 32'd0);
    chk_bank("post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
